// File: rtl/scratchpad_banked_pkg.sv
// Shared definitions for the banked scratchpad: op codes, FSM encoding and
// width helpers used to size the logical and physical register arrays.
package scratchpad_pkg;

  localparam logic [2:0] SP_RD_NIB   = 3'd0;
  localparam logic [2:0] SP_WR_NIB   = 3'd1;
  localparam logic [2:0] SP_RD_PAIR  = 3'd2;
  localparam logic [2:0] SP_WR_PAIR  = 3'd3;
  localparam logic [2:0] SP_XCH      = 3'd4;
  localparam logic [2:0] SP_INC      = 3'd5;
  localparam logic [2:0] SP_SEL_BANK = 3'd6;
  localparam logic [2:0] SP_NOP      = 3'd7;

  typedef enum logic [0:0] {
    SP_IDLE = 1'b0,
    SP_RMW  = 1'b1
  } sp_state_e;

  function automatic int sp_aw(input int num_pairs);
    return $clog2(32'd2 * num_pairs);
  endfunction

  function automatic int sp_bw(input int num_banks);
    return (num_banks > 32'd1) ? $clog2(num_banks) : 32'd1;
  endfunction

  // Banked pairs are replicated per bank; the remaining pairs exist once.
  function automatic int sp_phys_pairs(input int num_pairs, input int num_banks,
                                       input int banked_pairs);
    return num_banks * banked_pairs + (num_pairs - banked_pairs);
  endfunction

  function automatic int sp_phys_regs(input int num_pairs, input int num_banks,
                                      input int banked_pairs);
    return 32'd2 * sp_phys_pairs(num_pairs, num_banks, banked_pairs);
  endfunction

  function automatic int sp_ppw(input int num_pairs, input int num_banks,
                                input int banked_pairs);
    int pp;
    pp = sp_phys_pairs(num_pairs, num_banks, banked_pairs);
    return (pp > 32'd1) ? $clog2(pp) : 32'd1;
  endfunction

endpackage

// File: rtl/scratchpad_banked_if.sv
// Command/response port of the banked scratchpad; the decode logic is the
// master, the scratchpad the slave.
interface scratchpad_banked_if #(
  parameter int AW = 4,
  parameter int DW = 8
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic [2:0]    cmd_op;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid;
  logic [DW-1:0] rsp_data;
  logic          rsp_zero;
  logic          rsp_carry;

  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_wdata,
    input  cmd_ready, rsp_valid, rsp_data, rsp_zero, rsp_carry
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_wdata,
    output cmd_ready, rsp_valid, rsp_data, rsp_zero, rsp_carry
  );
endinterface

// File: rtl/scratchpad_bank_map.sv
// Combinational logical-pair to physical-pair translation: low pairs are
// selected by the current bank, the rest live in a shared region above them.
module scratchpad_bank_map
  import scratchpad_pkg::*;
#(
  parameter int NUM_PAIRS    = 8,
  parameter int NUM_BANKS    = 2,
  parameter int BANKED_PAIRS = 4,
  localparam int AW  = sp_aw(NUM_PAIRS),
  localparam int BW  = sp_bw(NUM_BANKS),
  localparam int PPW = sp_ppw(NUM_PAIRS, NUM_BANKS, BANKED_PAIRS)
) (
  input  logic [AW-1:0]  addr_i,
  input  logic [BW-1:0]  bank_i,
  output logic [PPW-1:0] phys_pair_o
);

  int   pair_s;
  int   phys_s;
  logic unused_s;

  // map the logical pair into the banked or shared physical region
  always_comb begin
    pair_s = 32'(addr_i[AW-1:1]);
    if (pair_s < BANKED_PAIRS) begin
      phys_s = 32'(bank_i) * BANKED_PAIRS + pair_s;
    end else begin
      phys_s = NUM_BANKS * BANKED_PAIRS + (pair_s - BANKED_PAIRS);
    end
    phys_pair_o = phys_s[PPW-1:0];
  end

  assign unused_s = ^{addr_i[0], phys_s[31:PPW]};

endmodule

// File: rtl/scratchpad_banked.sv
// Bank-switched scratchpad register array with a two-cycle read-modify-write path.
// Optional even-parity protection is built when SCRATCHPAD_PARITY_EN is defined.
module scratchpad_banked
  import scratchpad_pkg::*;
#(
  parameter int DATA_W       = 4,
  parameter int NUM_PAIRS    = 8,
  parameter int NUM_BANKS    = 2,
  parameter int BANKED_PAIRS = 4
) (
  input  logic                         sysclk,
  input  logic                         poc_n,
  scratchpad_banked_if.slave           sp,
  output logic [sp_bw(NUM_BANKS)-1:0]  bank,
  input  logic                         par_inject,
  output logic                         par_err
);

  localparam int AW    = sp_aw(NUM_PAIRS);
  localparam int BW    = sp_bw(NUM_BANKS);
  localparam int DW    = 2 * DATA_W;
  localparam int PPW   = sp_ppw(NUM_PAIRS, NUM_BANKS, BANKED_PAIRS);
  localparam int PAW   = PPW + 1;
  localparam int NREGS = sp_phys_regs(NUM_PAIRS, NUM_BANKS, BANKED_PAIRS);
  localparam logic [DATA_W-1:0] ONE_N  = DATA_W'(1'b1);
  localparam logic [DATA_W-1:0] ZERO_N = {DATA_W{1'b0}};
  localparam logic [DATA_W-1:0] ONES_N = {DATA_W{1'b1}};

  sp_state_e         state_q, state_d;
  logic [DATA_W-1:0] mem_q [NREGS];
  logic [DW-1:0]     row_q, row_d;
  logic [PAW-1:0]    rmw_addr_q, rmw_addr_d;
  logic              rmw_inc_q, rmw_inc_d;
  logic [DATA_W-1:0] rmw_wdata_q, rmw_wdata_d;
  logic [BW-1:0]     bank_q, bank_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]     rsp_data_q, rsp_data_d;
  logic              rsp_zero_q, rsp_zero_d;
  logic              rsp_carry_q, rsp_carry_d;

  logic [PPW-1:0]    pp_s;
  logic [PAW-1:0]    ev_s, od_s, nib_s;
  logic              accept_s;
  logic              we0_s, we1_s;
  logic [PAW-1:0]    wa0_s, wa1_s;
  logic [DATA_W-1:0] wd0_s, wd1_s;
  logic              chk0_s, chk1_s;
  logic [PAW-1:0]    ca0_s, ca1_s;
  logic [DATA_W-1:0] old_s, new_s;

  scratchpad_bank_map #(
    .NUM_PAIRS   (NUM_PAIRS),
    .NUM_BANKS   (NUM_BANKS),
    .BANKED_PAIRS(BANKED_PAIRS)
  ) u_bank_map (
    .addr_i     (sp.cmd_addr),
    .bank_i     (bank_q),
    .phys_pair_o(pp_s)
  );

  assign ev_s     = {pp_s, 1'b0};
  assign od_s     = {pp_s, 1'b1};
  assign nib_s    = {pp_s, sp.cmd_addr[0]};
  assign accept_s = sp.cmd_valid & sp.cmd_ready;
  // the row buffer holds {even, odd}; the RMW target picks its half
  assign old_s    = rmw_addr_q[0] ? row_q[DATA_W-1:0] : row_q[DW-1:DATA_W];
  assign new_s    = rmw_inc_q ? (old_s + ONE_N) : rmw_wdata_q;

  assign sp.cmd_ready = poc_n & (state_q == SP_IDLE);
  assign sp.rsp_valid = rsp_valid_q;
  assign sp.rsp_data  = rsp_data_q;
  assign sp.rsp_zero  = rsp_zero_q;
  assign sp.rsp_carry = rsp_carry_q;
  assign bank         = bank_q;

  // next-state, write-port, parity-check and response decode
  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    rmw_addr_d  = rmw_addr_q;
    rmw_inc_d   = rmw_inc_q;
    rmw_wdata_d = rmw_wdata_q;
    bank_d      = bank_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = {DW{1'b0}};
    rsp_zero_d  = 1'b0;
    rsp_carry_d = 1'b0;
    we0_s       = 1'b0;
    we1_s       = 1'b0;
    wa0_s       = nib_s;
    wa1_s       = od_s;
    wd0_s       = sp.cmd_wdata[DATA_W-1:0];
    wd1_s       = sp.cmd_wdata[DATA_W-1:0];
    chk0_s      = 1'b0;
    chk1_s      = 1'b0;
    ca0_s       = nib_s;
    ca1_s       = od_s;
    case (state_q)
      SP_IDLE: begin
        if (accept_s) begin
          row_d       = {mem_q[ev_s], mem_q[od_s]};
          rsp_valid_d = 1'b1;
          case (sp.cmd_op)
            SP_RD_NIB: begin
              rsp_data_d = {ZERO_N, mem_q[nib_s]};
              chk0_s     = 1'b1;
            end
            SP_WR_NIB: begin
              we0_s      = 1'b1;
              rsp_data_d = {ZERO_N, sp.cmd_wdata[DATA_W-1:0]};
            end
            SP_RD_PAIR: begin
              rsp_data_d = {mem_q[ev_s], mem_q[od_s]};
              chk0_s     = 1'b1;
              ca0_s      = ev_s;
              chk1_s     = 1'b1;
            end
            SP_WR_PAIR: begin
              we0_s      = 1'b1;
              wa0_s      = ev_s;
              wd0_s      = sp.cmd_wdata[DW-1:DATA_W];
              we1_s      = 1'b1;
              rsp_data_d = sp.cmd_wdata;
            end
            SP_XCH, SP_INC: begin
              rsp_valid_d = 1'b0;
              state_d     = SP_RMW;
              rmw_addr_d  = nib_s;
              rmw_inc_d   = (sp.cmd_op == SP_INC);
              rmw_wdata_d = sp.cmd_wdata[DATA_W-1:0];
              chk0_s      = 1'b1;
            end
            SP_SEL_BANK: begin
              if (32'(sp.cmd_wdata) < NUM_BANKS) begin
                bank_d = sp.cmd_wdata[BW-1:0];
              end else begin
                rsp_carry_d = 1'b1;
              end
            end
            default: begin
              rsp_data_d = {DW{1'b0}};
            end
          endcase
        end else begin
          rsp_valid_d = 1'b0;
        end
      end
      SP_RMW: begin
        we0_s       = 1'b1;
        wa0_s       = rmw_addr_q;
        wd0_s       = new_s;
        rsp_valid_d = 1'b1;
        rsp_data_d  = {ZERO_N, (rmw_inc_q ? new_s : old_s)};
        rsp_zero_d  = rmw_inc_q & (new_s == ZERO_N);
        rsp_carry_d = rmw_inc_q & (old_s == ONES_N);
        state_d     = SP_IDLE;
      end
      default: begin
        state_d = SP_IDLE;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge sysclk or negedge poc_n) begin
    if (!poc_n) begin
      state_q <= SP_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // row buffer, RMW context, bank select and registered response
  always_ff @(posedge sysclk or negedge poc_n) begin
    if (!poc_n) begin
      row_q       <= {DW{1'b0}};
      rmw_addr_q  <= {PAW{1'b0}};
      rmw_inc_q   <= 1'b0;
      rmw_wdata_q <= ZERO_N;
      bank_q      <= {BW{1'b0}};
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= {DW{1'b0}};
      rsp_zero_q  <= 1'b0;
      rsp_carry_q <= 1'b0;
    end else begin
      row_q       <= row_d;
      rmw_addr_q  <= rmw_addr_d;
      rmw_inc_q   <= rmw_inc_d;
      rmw_wdata_q <= rmw_wdata_d;
      bank_q      <= bank_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_zero_q  <= rsp_zero_d;
      rsp_carry_q <= rsp_carry_d;
    end
  end

  // physical register storage, two write ports for pair writes
  always_ff @(posedge sysclk or negedge poc_n) begin
    if (!poc_n) begin
      for (int i = 0; i < NREGS; i++) begin
        mem_q[i] <= ZERO_N;
      end
    end else begin
      if (we0_s) begin
        mem_q[wa0_s] <= wd0_s;
      end
      if (we1_s) begin
        mem_q[wa1_s] <= wd1_s;
      end
    end
  end

`ifdef SCRATCHPAD_PARITY_EN
  logic par_q [NREGS];
  logic par_err_q;

  function automatic logic sp_even_par(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction

  // stored parity bit per register, optionally corrupted for test
  always_ff @(posedge sysclk or negedge poc_n) begin
    if (!poc_n) begin
      for (int i = 0; i < NREGS; i++) begin
        par_q[i] <= 1'b0;
      end
    end else begin
      if (we0_s) begin
        par_q[wa0_s] <= sp_even_par(wd0_s) ^ par_inject;
      end
      if (we1_s) begin
        par_q[wa1_s] <= sp_even_par(wd1_s) ^ par_inject;
      end
    end
  end

  // sticky error flag raised by any read of a register with bad parity
  always_ff @(posedge sysclk or negedge poc_n) begin
    if (!poc_n) begin
      par_err_q <= 1'b0;
    end else if ((chk0_s && (sp_even_par(mem_q[ca0_s]) != par_q[ca0_s])) ||
                 (chk1_s && (sp_even_par(mem_q[ca1_s]) != par_q[ca1_s]))) begin
      par_err_q <= 1'b1;
    end else begin
      par_err_q <= par_err_q;
    end
  end

  assign par_err = par_err_q;
`else
  logic unused_s;

  assign par_err  = 1'b0;
  assign unused_s = ^{par_inject, chk0_s, chk1_s, ca0_s, ca1_s};
`endif

endmodule
